morse_mark_tokenizer: RTL and testbench



---
 rtl/morse_mark_tokenizer.sv | 90 +++++++++
 tb/tb_morse_mark_tokenizer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/morse_mark_tokenizer.sv
// morse_mark_tokenizer: times key marks/spaces in prescaled ticks and packs dots/dashes into letter codes
module morse_mark_tokenizer #(
  parameter int TICK_DIV   = 16,
  parameter int DASH_TICKS = 3,
  parameter int GAP_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_inp,
  input  logic       ter,
  output logic [4:0] sym_code,
  output logic [2:0] sym_len,
  output logic       sym_valid,
  output logic       sym_err,
  output logic       busy
);
  localparam int MAX_LEN = 5;
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
  state_t state, state_n;
  logic s1, key_s, tick, emit, chg;
  logic [PW-1:0] pcnt;
  logic [7:0] dur;
  logic [4:0] acc_code, acc_code_n;
  logic [2:0] acc_len, acc_len_n;
  logic acc_err, acc_err_n;
  assign tick = pcnt == PW'(TICK_DIV - 1);
  assign chg  = state_n != state;
  assign busy = state != IDLE;
  always_comb begin
    state_n    = state;
    acc_code_n = acc_code;
    acc_len_n  = acc_len;
    acc_err_n  = acc_err;
    emit       = 1'b0;
    case (state)
      IDLE: state_n = key_s ? MARK : IDLE;
      MARK:
        if (!key_s) begin
          state_n = SPACE;
          // a zero-tick mark is a glitch; only drop back to IDLE if no letter is open
          if (dur == 8'd0) state_n = acc_len != 3'd0 ? SPACE : IDLE;
          else if (acc_len < 3'(MAX_LEN)) begin
            acc_code_n[acc_len] = dur >= 8'(DASH_TICKS);
            acc_len_n = acc_len + 3'd1;
          end else acc_err_n = 1'b1;
        end
      SPACE:
        if (dur >= 8'(GAP_TICKS) || ter) begin
          emit       = 1'b1;
          state_n    = IDLE;
          acc_code_n = '0;
          acc_len_n  = '0;
          acc_err_n  = 1'b0;
        end else if (key_s) state_n = MARK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      key_s     <= 1'b0;
      state     <= IDLE;
      pcnt      <= '0;
      dur       <= '0;
      acc_code  <= '0;
      acc_len   <= '0;
      acc_err   <= 1'b0;
      sym_code  <= '0;
      sym_len   <= '0;
      sym_err   <= 1'b0;
      sym_valid <= 1'b0;
    end else begin
      s1        <= serial_inp;
      key_s     <= s1;
      state     <= state_n;
      pcnt      <= (chg || tick) ? '0 : pcnt + 1'b1;
      dur       <= chg ? 8'd0 : (tick && dur != 8'hff) ? dur + 8'd1 : dur;
      acc_code  <= acc_code_n;
      acc_len   <= acc_len_n;
      acc_err   <= acc_err_n;
      sym_valid <= emit;
      if (emit) begin
        sym_code <= acc_code;
        sym_len  <= acc_len;
        sym_err  <= acc_err;
      end
    end
  end
endmodule

// File: tb/tb_morse_mark_tokenizer.sv
// tb_morse_mark_tokenizer: directed table, hand-written corner sequences and random letters vs a letter-level model
module tb_morse_mark_tokenizer;
  logic clk = 1'b0, rst = 1'b1, serial_inp = 1'b0, ter = 1'b0;
  logic [4:0] sym_code;
  logic [2:0] sym_len;
  logic sym_valid, sym_err, busy;
  int vectors = 0, errors = 0;
  typedef struct {logic [4:0] code; logic [2:0] len; logic err;} tok_t;
  typedef struct {int n; logic [6:0] marks; bit use_ter; logic [4:0] code; logic [2:0] len; logic err;} vec_t;
  tok_t got[$];
  vec_t tbl[8];
  logic prev_v = 1'b0;

  morse_mark_tokenizer #(.TICK_DIV(4), .DASH_TICKS(3), .GAP_TICKS(3)) dut (
    .clk(clk), .rst(rst), .serial_inp(serial_inp), .ter(ter),
    .sym_code(sym_code), .sym_len(sym_len), .sym_valid(sym_valid),
    .sym_err(sym_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sym_valid) begin
      got.push_back('{sym_code, sym_len, sym_err});
      check("no_back_to_back_valid", 32'(prev_v), 32'd0);
    end
    prev_v = sym_valid;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    serial_inp = v;
    hold(n);
  endtask

  // dot/dash lengths in clk cycles: dots give 1-2 ticks, dashes >= 3 ticks
  task automatic send(input logic [6:0] marks, input int n, input bit use_ter, input bit rnd);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, marks[i] ? (rnd ? int'($urandom_range(13, 28)) : 16) : (rnd ? int'($urandom_range(5, 12)) : 8));
      if (i < n - 1) drive(1'b0, rnd ? int'($urandom_range(1, 12)) : 8);
    end
    if (use_ter) begin
      drive(1'b0, rnd ? int'($urandom_range(3, 10)) : 4);
      ter = 1'b1;
      hold(1);
      ter = 1'b0;
      hold(6);
    end else drive(1'b0, rnd ? int'($urandom_range(14, 30)) : 20);
  endtask

  task automatic expect_tok(input string name, input logic [4:0] code, input logic [2:0] len, input logic err);
    tok_t t;
    hold(4);
    check({name, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      t = got.pop_front();
      check({name, "_code"}, 32'(t.code), 32'(code));
      check({name, "_len"}, 32'(t.len), 32'(len));
      check({name, "_err"}, 32'(t.err), 32'(err));
    end
    got.delete();
  endtask

  initial begin
    int lat;
    tbl[0] = '{2, 7'b0000010, 1'b0, 5'b00010, 3'd2, 1'b0};
    tbl[1] = '{1, 7'b0000000, 1'b1, 5'b00000, 3'd1, 1'b0};
    tbl[2] = '{1, 7'b0000001, 1'b0, 5'b00001, 3'd1, 1'b0};
    tbl[3] = '{5, 7'b0011111, 1'b0, 5'b11111, 3'd5, 1'b0};
    tbl[4] = '{6, 7'b0000000, 1'b0, 5'b00000, 3'd5, 1'b1};
    tbl[5] = '{4, 7'b0000001, 1'b0, 5'b00001, 3'd4, 1'b0};
    tbl[6] = '{7, 7'b1111111, 1'b1, 5'b11111, 3'd5, 1'b1};
    tbl[7] = '{4, 7'b0001011, 1'b1, 5'b01011, 3'd4, 1'b0};
    for (int i = 0; i < 3; i++) begin
      serial_inp = i[0];
      @(negedge clk);
      check("reset_outputs", 32'({sym_code, sym_len, sym_valid, sym_err, busy}), 32'd0);
      @(posedge clk);
      #1;
    end
    serial_inp = 1'b0;
    rst = 1'b0;
    hold(5);
    // letter A with gap-to-strobe latency measured from the falling key edge
    drive(1'b1, 8);
    drive(1'b0, 8);
    drive(1'b1, 4);
    check("busy_in_mark", 32'(busy), 32'd1);
    drive(1'b1, 12);
    serial_inp = 1'b0;
    lat = 41;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (sym_valid) begin
        lat = c;
        break;
      end
    end
    check("gap_latency", 32'(lat), 32'd16);
    hold(6);
    check("busy_after_gap", 32'(busy), 32'd0);
    expect_tok("letter_A", 5'b00010, 3'd2, 1'b0);
    // forced terminate: strobe in the cycle after ter is sampled
    drive(1'b1, 8);
    drive(1'b0, 4);
    ter = 1'b1;
    @(posedge clk);
    #1;
    ter = 1'b0;
    @(negedge clk);
    check("ter_latency", 32'(sym_valid), 32'd1);
    expect_tok("ter_E", 5'b00000, 3'd1, 1'b0);
    // glitch rejection
    drive(1'b1, 3);
    drive(1'b0, 20);
    check("glitch_no_valid", got.size(), 0);
    check("glitch_busy", 32'(busy), 32'd0);
    // longest intra-letter space still joins marks
    drive(1'b1, 8);
    drive(1'b0, 12);
    drive(1'b1, 8);
    drive(1'b0, 20);
    expect_tok("gap_12_joins", 5'b00000, 3'd2, 1'b0);
    // reset in the middle of a letter
    drive(1'b1, 16);
    drive(1'b0, 8);
    drive(1'b1, 5);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    drive(1'b0, 20);
    check("reset_mid_no_valid", got.size(), 0);
    check("reset_mid_outputs", 32'({sym_code, sym_len, sym_err, busy}), 32'd0);
    drive(1'b1, 8);
    drive(1'b0, 20);
    expect_tok("after_reset_dot", 5'b00000, 3'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].marks, tbl[i].n, tbl[i].use_ter, 1'b0);
      expect_tok($sformatf("table_%0d", i), tbl[i].code, tbl[i].len, tbl[i].err);
    end
    for (int k = 0; k < 40; k++) begin
      logic [6:0] m;
      logic [4:0] code;
      int n, len;
      m = 7'($urandom);
      n = $urandom_range(1, 7);
      len = n > 5 ? 5 : n;
      code = '0;
      for (int b = 0; b < len; b++) code[b] = m[b];
      send(m, n, 1'($urandom_range(0, 1)), 1'b1);
      expect_tok($sformatf("random_%0d", k), code, 3'(len), n > 5);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
